// File: rtl/bilat_sng_rx_pkg.sv
// Shared definitions for the bilateral stop-and-go (BSNG) keystream link:
// default seeds, LFSR tap masks, monitor state encoding and feedback helpers.
package bilat_sng_rx_pkg;

    localparam logic [31:0] DEF_SEED1  = 32'hACE1_2468;
    localparam logic [31:0] DEF_SEED2  = 32'h1357_9BDF;

    // Tap masks: LFSR1 uses bits 31,21,1,0 and LFSR2 uses bits 31,6,4,2,1,0
    localparam logic [31:0] LFSR1_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR2_TAPS = 32'h8000_0057;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } mon_state_e;

    function automatic logic lfsr_fb(input logic [31:0] q, input logic [31:0] taps);
        return ^(q & taps);
    endfunction

    function automatic logic [31:0] lfsr_shift(input logic [31:0] q, input logic [31:0] taps);
        return {q[30:0], lfsr_fb(q, taps)};
    endfunction

endpackage

// File: rtl/bilat_sng_rx_bsng_core.sv
// BSNG keystream generator: two clock-enabled Fibonacci LFSRs clocking each
// other stop-and-go style. Shared by the transmit and receive ends of the link.
module bsng_core
    import bilat_sng_rx_pkg::*;
#(
    parameter logic [31:0] SEED1 = DEF_SEED1,
    parameter logic [31:0] SEED2 = DEF_SEED2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] seed1,
    input  logic [31:0] seed2,
    output logic        ks
);

    logic [31:0] q1_r, q2_r;
    logic [31:0] src1_s, src2_s;
    logic [31:0] nxt1_s, nxt2_s;
    logic        en1_s, en2_s;

    // Select the working state (seeds on a frame start) and apply the step rule to it
    always_comb begin
        src1_s = q1_r;
        src2_s = q2_r;
        if (load) begin
            src1_s = seed1;
            src2_s = seed2;
        end else begin
            src1_s = q1_r;
            src2_s = q2_r;
        end

        // LFSR2 pauses on a 01 top pair; LFSR1 pauses on its own 01 pair only while LFSR2 runs
        en2_s = ~(~src2_s[31] & src2_s[30]);
        en1_s = ~(en2_s & ~src1_s[31] & src1_s[30]);

        nxt1_s = src1_s;
        nxt2_s = src2_s;
        if (en1_s) begin
            nxt1_s = lfsr_shift(src1_s, LFSR1_TAPS);
        end else begin
            nxt1_s = src1_s;
        end
        if (en2_s) begin
            nxt2_s = lfsr_shift(src2_s, LFSR2_TAPS);
        end else begin
            nxt2_s = src2_s;
        end
    end

    assign ks = src1_s[0] ^ src2_s[0];

    // LFSR state registers, advanced only on an accepted bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_r <= SEED1;
            q2_r <= SEED2;
        end else if (step) begin
            q1_r <= nxt1_s;
            q2_r <= nxt2_s;
        end
    end

endmodule

// File: rtl/bilat_sng_rx.sv
// BSNG link receiver: descrambles the serial stream with a local keystream and
// watches descrambled idle (all-zero) traffic to report lock and an error count.
module bilat_sng_rx
    import bilat_sng_rx_pkg::*;
#(
    parameter logic [31:0] SEED1    = DEF_SEED1,
    parameter logic [31:0] SEED2    = DEF_SEED2,
    parameter int          LOCK_CNT = 32,
    parameter int          LOSS_CNT = 4,
    parameter int          ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_we,
    input  logic [31:0]     seed1_in,
    input  logic [31:0]     seed2_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_data,
    input  logic            in_sof,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    output logic            locked,
    output logic [ERRW-1:0] err_cnt
);

    localparam int            ZW     = $clog2(LOCK_CNT + 1);
    localparam int            EW     = $clog2(LOSS_CNT + 1);
    localparam logic [ZW-1:0] LOCK_V = ZW'(LOCK_CNT);
    localparam logic [EW-1:0] LOSS_V = EW'(LOSS_CNT);

    logic [31:0]     seed1_r, seed2_r;
    logic            out_valid_r, out_data_r, locked_r;
    logic [ERRW-1:0] err_cnt_r, err_cnt_n_s;
    mon_state_e      state_r, state_n_s;
    logic [ZW-1:0]   zrun_r, zrun_n_s, zrun_inc_s;
    logic [EW-1:0]   erun_r, erun_n_s, erun_inc_s;
    logic            in_ready_s, acc_s, sof_acc_s, ks_s, bit_s;

    assign in_ready_s = ~out_valid_r | out_ready;
    assign acc_s      = in_valid & in_ready_s;
    assign sof_acc_s  = acc_s & in_sof;
    assign bit_s      = in_data ^ ks_s;
    assign zrun_inc_s = zrun_r + {{(ZW-1){1'b0}}, 1'b1};
    assign erun_inc_s = erun_r + {{(EW-1){1'b0}}, 1'b1};

    bsng_core #(
        .SEED1 (SEED1),
        .SEED2 (SEED2)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .step  (acc_s),
        .load  (sof_acc_s),
        .seed1 (seed1_r),
        .seed2 (seed2_r),
        .ks    (ks_s)
    );

    // Seed registers; a zero write falls back to the default seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed1_r <= SEED1;
            seed2_r <= SEED2;
        end else if (seed_we) begin
            seed1_r <= (seed1_in == 32'h0000_0000) ? SEED1 : seed1_in;
            seed2_r <= (seed2_in == 32'h0000_0000) ? SEED2 : seed2_in;
        end
    end

    // Single-entry output register with pass-through ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 1'b0;
        end else if (acc_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bit_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Lock monitor next-state: zero runs acquire lock, one runs lose it
    always_comb begin
        state_n_s   = state_r;
        zrun_n_s    = zrun_r;
        erun_n_s    = erun_r;
        err_cnt_n_s = err_cnt_r;
        if (acc_s) begin
            case (state_r)
                HUNT: begin
                    if (bit_s) begin
                        zrun_n_s = {ZW{1'b0}};
                    end else if (zrun_inc_s == LOCK_V) begin
                        zrun_n_s  = {ZW{1'b0}};
                        state_n_s = LOCKED;
                    end else begin
                        zrun_n_s = zrun_inc_s;
                    end
                end
                LOCKED: begin
                    if (bit_s) begin
                        if (err_cnt_r != {ERRW{1'b1}}) begin
                            err_cnt_n_s = err_cnt_r + {{(ERRW-1){1'b0}}, 1'b1};
                        end else begin
                            err_cnt_n_s = err_cnt_r;
                        end
                        if (erun_inc_s == LOSS_V) begin
                            erun_n_s  = {EW{1'b0}};
                            state_n_s = HUNT;
                        end else begin
                            erun_n_s = erun_inc_s;
                        end
                    end else begin
                        erun_n_s = {EW{1'b0}};
                    end
                end
                default: begin
                    state_n_s = HUNT;
                    zrun_n_s  = {ZW{1'b0}};
                    erun_n_s  = {EW{1'b0}};
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Lock monitor state, run counters and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= HUNT;
            zrun_r    <= {ZW{1'b0}};
            erun_r    <= {EW{1'b0}};
            err_cnt_r <= {ERRW{1'b0}};
            locked_r  <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            zrun_r    <= zrun_n_s;
            erun_r    <= erun_n_s;
            err_cnt_r <= err_cnt_n_s;
            locked_r  <= (state_n_s == LOCKED);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign locked    = locked_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_bilat_sng_rx.sv
// Directed bench for the BSNG receiver against an independent behavioural
// keystream transmitter model.
module tb_bilat_sng_rx;

    localparam logic [31:0] SEED1 = 32'hACE1_2468;
    localparam logic [31:0] SEED2 = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_we = 1'b0;
    logic [31:0] seed1_in = 32'h0;
    logic [31:0] seed2_in = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_data = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_data;
    logic        locked;
    logic [15:0] err_cnt;

    bilat_sng_rx dut (
        .clk       (clk),
        .rst       (rst),
        .seed_we   (seed_we),
        .seed1_in  (seed1_in),
        .seed2_in  (seed2_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // transmitter model state and its seed registers
    logic [31:0] m1, m2, ms1, ms2;
    logic        we_req = 1'b0;
    logic [31:0] s1_req = 32'h0;
    logic [31:0] s2_req = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m1 = SEED1; m2 = SEED2; ms1 = SEED1; ms2 = SEED2;
    endtask

    task automatic model_ks(input logic sof, output logic ks);
        logic [31:0] a, b;
        logic e1, e2, f1, f2;
        a = sof ? ms1 : m1;
        b = sof ? ms2 : m2;
        ks = a[0] ^ b[0];
        e2 = b[31] | ~b[30];
        e1 = ~e2 | a[31] | ~a[30];
        f1 = a[31] ^ a[21] ^ a[1] ^ a[0];
        f2 = b[31] ^ b[6] ^ b[4] ^ b[2] ^ b[1] ^ b[0];
        if (e1) a = {a[30:0], f1};
        if (e2) b = {b[30:0], f2};
        m1 = a; m2 = b;
    endtask

    task automatic apply_seed_req();
        if (we_req) begin
            ms1 = (s1_req == 32'h0) ? SEED1 : s1_req;
            ms2 = (s2_req == 32'h0) ? SEED2 : s2_req;
        end
        seed_we = 1'b0; we_req = 1'b0;
    endtask

    // one accepted bit (out_ready is high whenever this is used)
    task automatic push(input logic din, input logic sof, output logic dout);
        @(negedge clk);
        in_valid = 1'b1; in_data = din; in_sof = sof;
        seed_we = we_req; seed1_in = s1_req; seed2_in = s2_req;
        @(posedge clk); #1;
        dout = out_data;
        in_valid = 1'b0; in_sof = 1'b0;
        apply_seed_req();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0; seed_we = we_req; seed1_in = s1_req; seed2_in = s2_req;
        @(posedge clk); #1;
        apply_seed_req();
    endtask

    // scrambled plaintext p (optionally corrupted) -> receiver output
    task automatic xfer(input logic p, input logic sof, input logic flip, output logic got);
        logic ks;
        model_ks(sof, ks);
        push(p ^ ks ^ flip, sof, got);
    endtask

    // raw zero input, so the output is the keystream itself
    task automatic raw_stream(input int n, input logic sof0, output int bad,
                              output logic [63:0] bits);
        logic ks, got;
        bad = 0; bits = 64'h0;
        for (int i = 0; i < n; i++) begin
            model_ks(sof0 && (i == 0), ks);
            push(1'b0, sof0 && (i == 0), got);
            bits[i] = got;
            if (got !== ks) bad++;
        end
    endtask

    initial begin
        logic [63:0] bits;
        logic        got;
        logic        ks;
        int          bad;
        int          stall_bad;

        model_reset();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk); rst = 1'b0;

        // 64 zero bits with SOF: output is the keystream, starting 1,1,0,0
        raw_stream(64, 1'b1, bad, bits);
        chk("ks_first4", bits[3:0], 4'b0011);
        chk("ks_vs_model", bad, 0);
        chk("stream_valid", out_valid, 1'b1);
        idle_cycle();
        chk("valid_drain", out_valid, 1'b0);
        @(negedge clk); out_ready = 1'b0; #1;
        chk("ready_when_empty", in_ready, 1'b1);
        out_ready = 1'b1;

        // loopback of 200 plaintext zeros from reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            xfer(1'b0, i == 0, 1'b0, got);
            if (got !== 1'b0) bad++;
            if (i == 30) chk("locked_after_31", locked, 1'b0);
            if (i == 31) chk("locked_after_32", locked, 1'b1);
        end
        chk("loop_zero", bad, 0);
        chk("loop_locked", locked, 1'b1);
        chk("loop_err0", err_cnt, 16'd0);

        // three isolated errors while locked
        bad = 0;
        for (int j = 0; j < 30; j++) begin
            logic f;
            f = (j == 5) || (j == 15) || (j == 25);
            xfer(1'b0, 1'b0, f, got);
            if (got !== f) bad++;
        end
        chk("iso_data", bad, 0);
        chk("iso_err3", err_cnt, 16'd3);
        chk("iso_locked", locked, 1'b1);

        // four consecutive errors drop lock
        for (int j = 0; j < 4; j++) begin
            xfer(1'b0, 1'b0, 1'b1, got);
            if (j == 2) chk("locked_after_3err", locked, 1'b1);
        end
        chk("unlock_at_4err", locked, 1'b0);
        chk("err7", err_cnt, 16'd7);
        xfer(1'b0, 1'b0, 1'b1, got);
        chk("err_not_counted_hunt", err_cnt, 16'd7);

        // backpressure: out_ready low for 10 cycles mid-stream
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            xfer(i % 3 == 0, 1'b0, 1'b0, got);
            if (got !== (i % 3 == 0)) bad++;
        end
        chk("pre_stall", bad, 0);
        model_ks(1'b0, ks);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 1'b0 ^ ks; in_sof = 1'b0;
        stall_bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 1'b1) stall_bad++;
        end
        chk("stall_hold", stall_bad, 0);
        chk("stall_in_ready", in_ready, 1'b0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", out_data, 1'b0);
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            xfer(i % 2 == 1, 1'b0, 1'b0, got);
            if (got !== (i % 2 == 1)) bad++;
        end
        chk("post_stall", bad, 0);

        // seed write (zero seed1 -> default) then SOF
        we_req = 1'b1; s1_req = 32'h0; s2_req = 32'h1;
        idle_cycle();
        raw_stream(20, 1'b1, bad, bits);
        chk("seed_first_bit", bits[0], 1'b1);
        chk("seed_stream", bad, 0);
        we_req = 1'b1; s1_req = 32'hDEAD_BEEF; s2_req = 32'h0123_4567;
        raw_stream(20, 1'b0, bad, bits);
        chk("seed_we_running", bad, 0);

        // seed write together with SOF: the SOF still uses the previous seeds
        we_req = 1'b1; s1_req = 32'h0; s2_req = 32'h0;
        raw_stream(16, 1'b1, bad, bits);
        chk("sof_old_seed_bit", bits[0], 1'b0);
        chk("sof_old_seed_stream", bad, 0);
        raw_stream(16, 1'b1, bad, bits);
        chk("zero_seeds_default", bits[3:0], 4'b0011);
        chk("zero_seeds_stream", bad, 0);

        // reset in the middle of a stream
        chk("err_before_rst", err_cnt, 16'd7);
        raw_stream(50, 1'b1, bad, bits);
        chk("pre_rst_stream", bad, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", out_data, 1'b0);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_err_cnt", err_cnt, 16'd0);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0; in_data = 1'b0;
        model_reset();
        raw_stream(20, 1'b1, bad, bits);
        chk("restart_first4", bits[3:0], 4'b0011);
        chk("restart_stream", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
